// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared constants for mem_bus_master (FSM state encoding, byte width, default memory depth)
package mem_bus_pkg;
  localparam int BYTE_W = 8;
  localparam int MEM_DEPTH_DEF = 16384;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD0  = 3'd1;
  localparam logic [2:0] S_RD1  = 3'd2;
  localparam logic [2:0] S_RD2  = 3'd3;
  localparam logic [2:0] S_WR0  = 3'd4;
  localparam logic [2:0] S_WR1  = 3'd5;
  localparam logic [2:0] S_RESP = 3'd6;
endpackage

// File: rtl/mem_bus_master.sv
// mem_bus_master: splits 16-bit word read/write requests into little-endian byte accesses on MainMemory
//   ports: clk, reset (async, active-high)
//          req_valid/req_ready/req_write/req_addr/req_wdata : word request from the control unit
//          rsp_valid/rsp_rdata/rsp_err                       : one-cycle response pulse, read word, range error
//          mem_addr/mem_wdata/mem_we/mem_rdata               : MainMemory port (read data one cycle after addr)
//   optional: define MEM_BUS_RANGE_CHECK_EN to reject requests with req_addr > MEM_DEPTH-2
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [BYTE_W-1:0] hi_q;
  logic [BYTE_W-1:0] lo_q;
  logic              err_q;
  logic              range_err;
  logic              unused;
  assign req_ready = state == S_IDLE;
  assign unused = ^{mem_rdata[DATA_W-1:BYTE_W], 32'(MEM_DEPTH)};
`ifdef MEM_BUS_RANGE_CHECK_EN
  assign range_err = $unsigned(32'(req_addr)) > $unsigned(32'(MEM_DEPTH - 2));
`else
  assign range_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          addr_q <= req_addr;
          hi_q   <= req_wdata[2*BYTE_W-1:BYTE_W];
          err_q  <= range_err;
          // an out-of-range request skips the memory and reuses WR1 as a one-cycle wait with mem_we low
          if (range_err) state <= S_WR1;
          else begin
            mem_addr  <= req_addr;
            mem_we    <= req_write;
            mem_wdata <= req_write ? {{(DATA_W-BYTE_W){1'b0}}, req_wdata[BYTE_W-1:0]} : mem_wdata;
            state     <= req_write ? S_WR0 : S_RD0;
          end
        end
        S_RD0: begin
          mem_addr <= addr_q + ADDR_W'(1);
          state    <= S_RD1;
        end
        S_RD1: begin
          lo_q  <= mem_rdata[BYTE_W-1:0];
          state <= S_RD2;
        end
        S_RD2: begin
          rsp_rdata <= DATA_W'({mem_rdata[BYTE_W-1:0], lo_q});
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          state     <= S_RESP;
        end
        S_WR0: begin
          mem_addr  <= addr_q + ADDR_W'(1);
          mem_wdata <= {{(DATA_W-BYTE_W){1'b0}}, hi_q};
          state     <= S_WR1;
        end
        S_WR1: begin
          mem_we    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          state     <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
